// File: rtl/ll_window_sum_if.sv
// ll_window_sum_if: sample/feature bus between the line-length stage, the window summer and the classifier
// Ports: din/din_valid/flush/thresh flow toward the summer (slave);
//        sum_out/sum_valid/det/filled/neg_err flow back to the master.
interface ll_window_sum_if #(
    parameter int DW    = 32,
    parameter int OUT_W = 40
);
    logic [DW-1:0]    din;
    logic             din_valid;
    logic             flush;
    logic [OUT_W-1:0] thresh;
    logic [OUT_W-1:0] sum_out;
    logic             sum_valid;
    logic             det;
    logic             filled;
    logic             neg_err;
    modport master (
        output din, din_valid, flush, thresh,
        input  sum_out, sum_valid, det, filled, neg_err
    );
    modport slave (
        input  din, din_valid, flush, thresh,
        output sum_out, sum_valid, det, filled, neg_err
    );
endinterface

// File: rtl/ll_window_sum.sv
// ll_window_sum: sliding-window line-length sum with hold-qualified threshold detection
// Ports: clk, rst (sync, active high); bus (slave) carries din, din_valid, flush, thresh in
//        and sum_out, sum_valid, det, filled, neg_err out.
module ll_window_sum #(
    parameter int DW       = 32,
    parameter int WIN_LOG2 = 8,
    parameter int OUT_W    = 40,
    parameter int HOLD     = 4
) (
    input  logic           clk,
    input  logic           rst,
    ll_window_sum_if.slave bus
);
    localparam int WIN = 2 ** WIN_LOG2;
    localparam int CW  = $clog2(HOLD + 1);
    typedef enum logic {FILL, RUN} state_t;
    state_t              state_q, state_d;
    logic [WIN_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [OUT_W-1:0]    acc_q, acc_d, sum_q, sum_d, acc_new;
    logic [CW-1:0]       det_cnt_q, det_cnt_d, det_cnt_nx;
    logic                sum_valid_q, sum_valid_d, det_q, det_d;
    logic                filled_q, filled_d, neg_err_q, neg_err_d;
    logic [DW-2:0]       buf_mem [WIN];
    logic [DW-2:0]       s, oldest;
    logic                take, emit;
    // Negative samples are clamped to zero, leaving the magnitude bits only.
    assign s      = bus.din[DW-1] ? '0 : bus.din[DW-2:0];
    assign oldest = buf_mem[wr_ptr_q];
    // Flush drops any coincident sample.
    assign take   = bus.din_valid & ~bus.flush;
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        det_cnt_d   = det_cnt_q;
        det_d       = det_q;
        filled_d    = filled_q;
        sum_valid_d = 1'b0;
        neg_err_d   = neg_err_q | (take & bus.din[DW-1]);
        // While filling the buffer slot being written is stale, so nothing is retired.
        acc_new     = state_q == RUN ? acc_q + OUT_W'(s) - OUT_W'(oldest) : acc_q + OUT_W'(s);
        det_cnt_nx  = acc_new > bus.thresh ? (det_cnt_q == CW'(HOLD) ? CW'(HOLD) : CW'(det_cnt_q + 1'b1)) : '0;
        // In FILL the write pointer doubles as the fill count.
        emit        = take & (state_q == RUN || wr_ptr_q == WIN_LOG2'(WIN - 1));
        if (bus.flush) begin
            state_d   = FILL;
            wr_ptr_d  = '0;
            acc_d     = '0;
            sum_d     = '0;
            det_cnt_d = '0;
            det_d     = 1'b0;
            filled_d  = 1'b0;
        end else if (take) begin
            acc_d    = acc_new;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (emit) begin
                state_d     = RUN;
                filled_d    = 1'b1;
                sum_d       = acc_new;
                sum_valid_d = 1'b1;
                if (state_q == RUN) begin
                    det_cnt_d = det_cnt_nx;
                    det_d     = det_cnt_nx == CW'(HOLD);
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            det_cnt_q   <= '0;
            sum_valid_q <= 1'b0;
            det_q       <= 1'b0;
            filled_q    <= 1'b0;
            neg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            det_cnt_q   <= det_cnt_d;
            sum_valid_q <= sum_valid_d;
            det_q       <= det_d;
            filled_q    <= filled_d;
            neg_err_q   <= neg_err_d;
        end
    end
    // Buffer contents need no reset: every slot is written before it is retired.
    always_ff @(posedge clk) begin
        if (take & ~rst) buf_mem[wr_ptr_q] <= s;
    end
    assign bus.sum_out   = sum_q;
    assign bus.sum_valid = sum_valid_q;
    assign bus.det       = det_q;
    assign bus.filled    = filled_q;
    assign bus.neg_err   = neg_err_q;
endmodule

// File: tb/tb_ll_window_sum.sv
// tb_ll_window_sum: directed bench for ll_window_sum with WIN=4, HOLD=2, thresh=12
module tb_ll_window_sum;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    ll_window_sum_if #(.DW(32), .OUT_W(40)) bus ();
    ll_window_sum #(.DW(32), .WIN_LOG2(2), .OUT_W(40), .HOLD(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic cyc(input logic [31:0] v, input logic vld, input logic fl);
        bus.din       = v;
        bus.din_valid = vld;
        bus.flush     = fl;
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_out(input string tag, input logic sv, input logic [39:0] sum,
                           input logic dt, input logic fi);
        chk({tag, ".sum_valid"}, 64'(bus.sum_valid), 64'(sv));
        chk({tag, ".sum_out"}, 64'(bus.sum_out), 64'(sum));
        chk({tag, ".det"}, 64'(bus.det), 64'(dt));
        chk({tag, ".filled"}, 64'(bus.filled), 64'(fi));
    endtask
    localparam logic [31:0] MAXV = 32'h7FFF_FFFF;
    initial begin
        rst           = 1'b1;
        bus.din       = '0;
        bus.din_valid = 1'b0;
        bus.flush     = 1'b0;
        bus.thresh    = 40'd12;
        @(negedge clk);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk_out("reset", 0, 0, 0, 0);
        chk("reset.neg_err", 64'(bus.neg_err), 0);
        rst = 1'b0;
        // T1 fill
        cyc(1, 1, 0); chk_out("t1.s1", 0, 0, 0, 0);
        cyc(2, 1, 0); chk_out("t1.s2", 0, 0, 0, 0);
        cyc(3, 1, 0); chk_out("t1.s3", 0, 0, 0, 0);
        cyc(4, 1, 0); chk_out("t1.s4", 1, 10, 0, 1);
        // T2 slide and detection
        cyc(5, 1, 0); chk_out("t2.14", 1, 14, 0, 1);
        cyc(6, 1, 0); chk_out("t2.18", 1, 18, 1, 1);
        cyc(0, 1, 0); chk_out("t2.15", 1, 15, 1, 1);
        cyc(0, 1, 0); chk_out("t2.11", 1, 11, 0, 1);
        // T3 gaps: window {5,6,0,0}
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0); chk_out("t3.idle_a", 0, 11, 0, 1);
        end
        cyc(9, 1, 0); chk_out("t3.15", 1, 15, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0); chk_out("t3.idle_b", 0, 15, 0, 1);
        end
        cyc(1, 1, 0); chk_out("t3.10", 1, 10, 0, 1);
        // T4 negative sample: window {0,0,9,1} -> retire 0, add 0
        chk("t4.neg_err_pre", 64'(bus.neg_err), 0);
        cyc(32'hFFFF_FFFB, 1, 0); chk_out("t4.neg", 1, 10, 0, 1);
        chk("t4.neg_err", 64'(bus.neg_err), 1);
        // T5 flush with coincident sample
        cyc(100, 1, 1); chk_out("t5.flush", 0, 0, 0, 0);
        chk("t5.neg_err_kept", 64'(bus.neg_err), 1);
        cyc(7, 1, 0); chk_out("t5.s1", 0, 0, 0, 0);
        cyc(7, 1, 0); chk_out("t5.s2", 0, 0, 0, 0);
        cyc(7, 1, 0); chk_out("t5.s3", 0, 0, 0, 0);
        cyc(7, 1, 0); chk_out("t5.s4", 1, 28, 0, 1);
        cyc(7, 1, 0); chk_out("t5.s5", 1, 28, 0, 1);
        cyc(7, 1, 0); chk_out("t5.s6", 1, 28, 1, 1);
        cyc(0, 0, 1); chk_out("t5.flush2", 0, 0, 0, 0);
        chk("t5.neg_err_kept2", 64'(bus.neg_err), 1);
        // rst clears neg_err and discards a partial window
        cyc(3, 1, 0);
        cyc(3, 1, 0);
        rst = 1'b1;
        cyc(0, 0, 0);
        rst = 1'b0;
        chk_out("rst_mid", 0, 0, 0, 0);
        chk("rst_mid.neg_err", 64'(bus.neg_err), 0);
        // T6 max value
        cyc(MAXV, 1, 0); chk_out("t6.s1", 0, 0, 0, 0);
        cyc(MAXV, 1, 0); chk_out("t6.s2", 0, 0, 0, 0);
        cyc(MAXV, 1, 0); chk_out("t6.s3", 0, 0, 0, 0);
        cyc(MAXV, 1, 0);
        chk("t6.s4.sum_valid", 64'(bus.sum_valid), 1);
        chk("t6.s4.sum_out", 64'(bus.sum_out), 64'h1_FFFF_FFFC);
        cyc(MAXV, 1, 0); chk_out("t6.s5", 1, 40'h1_FFFF_FFFC, 0, 1);
        cyc(MAXV, 1, 0); chk_out("t6.s6", 1, 40'h1_FFFF_FFFC, 1, 1);
        cyc(MAXV, 1, 0);
        cyc(MAXV, 1, 0); chk_out("t6.s8", 1, 40'h1_FFFF_FFFC, 1, 1);
        cyc(0, 0, 0); chk_out("t6.idle", 0, 40'h1_FFFF_FFFC, 1, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
